// File: rtl/bram_port_arbiter_if.sv
// Client/BRAM bundle for bram_port_arbiter: per-client request buses, the shared
// read-return path, and the single physical BRAM port.
interface bram_port_arbiter_if #(
    parameter int NUM_CLIENTS = 2,
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int OWNER_W     = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
);
    logic [NUM_CLIENTS-1:0]        req;
    logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr;
    logic [NUM_CLIENTS*DATA_W-1:0] cl_dout;
    logic [NUM_CLIENTS-1:0]        cl_we;
    logic [NUM_CLIENTS-1:0]        gnt;
    logic [DATA_W-1:0]             rd_data;
    logic [NUM_CLIENTS-1:0]        rd_valid;
    logic [OWNER_W-1:0]            owner;
    logic                          busy;
    logic [ADDR_W-1:0]             BRAM_addr;
    logic [DATA_W-1:0]             BRAM_dout;
    logic [DATA_W-1:0]             BRAM_din;
    logic                          BRAM_we;

    // Clients plus the BRAM macro.
    modport master (
        output req, cl_addr, cl_dout, cl_we, BRAM_din,
        input  gnt, rd_data, rd_valid, owner, busy, BRAM_addr, BRAM_dout, BRAM_we
    );

    // The arbiter itself.
    modport slave (
        input  req, cl_addr, cl_dout, cl_we, BRAM_din,
        output gnt, rd_data, rd_valid, owner, busy, BRAM_addr, BRAM_dout, BRAM_we
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Lock-based N-client arbiter in front of one single-port BRAM, with fixed or
// round-robin priority, optional hold timeout and owner-tagged read returns.
module bram_port_arbiter #(
    parameter int NUM_CLIENTS   = 2,
    parameter int ADDR_W        = 12,
    parameter int DATA_W        = 32,
    parameter int READ_LATENCY  = 2,
    parameter int PRIORITY_MODE = 0,
    parameter int MAX_HOLD      = 0
) (
    input logic               Clk,
    input logic               ResetN,
    bram_port_arbiter_if.slave bus
);
    localparam int OWNER_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam int HOLD_W  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                 state;
    logic [NUM_CLIENTS-1:0] gnt_r;
    logic [OWNER_W-1:0]     owner_r;
    logic                   busy_r;
    logic [OWNER_W-1:0]     rr_last;
    logic [HOLD_W-1:0]      hold_cnt;

    logic                   owner_req;
    logic                   owner_we;
    logic [NUM_CLIENTS-1:0] cand;
    logic                   any_other;
    logic [OWNER_W-1:0]     win;
    logic                   timeout;
    logic                   grant_now;
    logic                   drop_now;
    logic                   launch;

    logic                   vld_p [READ_LATENCY];
    logic [OWNER_W-1:0]     tag_p [READ_LATENCY];

    function automatic logic [OWNER_W-1:0] pick_fixed(input logic [NUM_CLIENTS-1:0] c);
        logic [OWNER_W-1:0] w;
        w = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (c[i]) w = OWNER_W'(i);
        end
        return w;
    endfunction

    function automatic logic [OWNER_W-1:0] pick_rr(input logic [NUM_CLIENTS-1:0] c,
                                                   input logic [OWNER_W-1:0]     last);
        logic [OWNER_W-1:0] w;
        logic               found;
        int                 idx;
        w     = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            idx = (int'(last) + k) % NUM_CLIENTS;
            if (!found && c[idx]) begin
                w     = OWNER_W'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    // Grant-cycle counter saturates at MAX_HOLD so a lone owner never wraps it.
    function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] c);
        if (MAX_HOLD == 0 || int'(c) >= MAX_HOLD) return c;
        return c + HOLD_W'(1);
    endfunction

    // gnt_r is the owner one-hot in GRANT and zero in IDLE, so it doubles as the owner mask.
    always_comb begin
        owner_req = |(bus.req & gnt_r);
        owner_we  = |(bus.cl_we & gnt_r);
        cand      = bus.req & ~gnt_r;
        any_other = |cand;
        win       = (PRIORITY_MODE == 1) ? pick_rr(cand, rr_last) : pick_fixed(cand);
        timeout   = (MAX_HOLD > 0) && owner_req && any_other && (int'(hold_cnt) >= MAX_HOLD);
        grant_now = any_other && ((state == IDLE) || !owner_req || timeout);
        drop_now  = (state == GRANT) && !owner_req && !any_other;
        launch    = busy_r && owner_req && !owner_we;
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state    <= IDLE;
            gnt_r    <= '0;
            owner_r  <= '0;
            busy_r   <= 1'b0;
            rr_last  <= OWNER_W'(NUM_CLIENTS - 1);
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_now) begin
                        state    <= GRANT;
                        gnt_r    <= NUM_CLIENTS'(1) << win;
                        owner_r  <= win;
                        busy_r   <= 1'b1;
                        rr_last  <= win;
                        hold_cnt <= HOLD_W'(1);
                    end
                end
                GRANT: begin
                    if (grant_now) begin
                        gnt_r    <= NUM_CLIENTS'(1) << win;
                        owner_r  <= win;
                        rr_last  <= win;
                        hold_cnt <= HOLD_W'(1);
                    end else if (drop_now) begin
                        state    <= IDLE;
                        gnt_r    <= '0;
                        busy_r   <= 1'b0;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_inc(hold_cnt);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Owner's slice goes straight to the BRAM; writes are suppressed on the release cycle.
    always_comb begin
        bus.BRAM_addr = '0;
        bus.BRAM_dout = '0;
        bus.BRAM_we   = 1'b0;
        if (busy_r) begin
            bus.BRAM_addr = bus.cl_addr[int'(owner_r)*ADDR_W +: ADDR_W];
            bus.BRAM_dout = bus.cl_dout[int'(owner_r)*DATA_W +: DATA_W];
            bus.BRAM_we   = owner_req & owner_we;
        end
    end

    // ---- read-token pipeline: stage p0 holds launches, last stage aligns with BRAM_din
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            for (int i = 0; i < READ_LATENCY; i++) vld_p[i] <= 1'b0;
        end else begin
            vld_p[0] <= launch;
            for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge Clk) begin
        tag_p[0] <= owner_r;
        for (int i = 1; i < READ_LATENCY; i++) tag_p[i] <= tag_p[i-1];
    end

    // ---- read return and registered status outputs
    always_comb begin
        bus.rd_valid = '0;
        if (vld_p[READ_LATENCY-1]) bus.rd_valid = NUM_CLIENTS'(1) << tag_p[READ_LATENCY-1];
        bus.rd_data = bus.BRAM_din;
        bus.gnt     = gnt_r;
        bus.owner   = owner_r;
        bus.busy    = busy_r;
    end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: a 2-client fixed-priority instance with
// hold timeout and a 4-client round-robin instance with 3-cycle read latency.
module tb_bram_port_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n_a;
    logic rst_n_b;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    bram_port_arbiter_if #(.NUM_CLIENTS(2), .ADDR_W(AW), .DATA_W(DW)) bus_a ();
    bram_port_arbiter_if #(.NUM_CLIENTS(4), .ADDR_W(AW), .DATA_W(DW)) bus_b ();

    bram_port_arbiter #(.NUM_CLIENTS(2), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2),
                        .PRIORITY_MODE(0), .MAX_HOLD(4))
        dut_a (.Clk(clk), .ResetN(rst_n_a), .bus(bus_a.slave));

    bram_port_arbiter #(.NUM_CLIENTS(4), .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(3),
                        .PRIORITY_MODE(1), .MAX_HOLD(0))
        dut_b (.Clk(clk), .ResetN(rst_n_b), .bus(bus_b.slave));

    function automatic logic [31:0] iw(input int i);
        return 32'h1000_0000 + 32'(i * 3);
    endfunction

    // BRAM models: contents reload while reset is held, synchronous write, fixed read latency.
    logic [31:0] mem_a [256];
    logic [31:0] pa [2];
    always @(posedge clk) begin
        if (!rst_n_a) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= iw(i);
        end else if (bus_a.BRAM_we) begin
            mem_a[bus_a.BRAM_addr] <= bus_a.BRAM_dout;
        end
        pa[0] <= mem_a[bus_a.BRAM_addr];
        pa[1] <= pa[0];
    end
    assign bus_a.BRAM_din = pa[1];

    logic [31:0] mem_b [256];
    logic [31:0] pb [3];
    always @(posedge clk) begin
        if (!rst_n_b) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= iw(i);
        end else if (bus_b.BRAM_we) begin
            mem_b[bus_b.BRAM_addr] <= bus_b.BRAM_dout;
        end
        pb[0] <= mem_b[bus_b.BRAM_addr];
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign bus_b.BRAM_din = pb[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [7:0]  a0;
        logic [7:0]  a1;
        logic [31:0] d1;
        logic [1:0]  e_gnt;
        logic        e_chk;
        logic [7:0]  e_addr;
        logic        e_we;
        logic [31:0] e_dout;
        logic [1:0]  e_rv;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [1:0] req, input logic [1:0] we, input logic [7:0] a0,
                       input logic [7:0] a1, input logic [31:0] d1, input logic [1:0] e_gnt,
                       input logic e_chk, input logic [7:0] e_addr, input logic e_we,
                       input logic [31:0] e_dout, input logic [1:0] e_rv, input logic [31:0] e_rd);
        vec_t v;
        v.req = req;     v.we = we;         v.a0 = a0;         v.a1 = a1;     v.d1 = d1;
        v.e_gnt = e_gnt; v.e_chk = e_chk;   v.e_addr = e_addr; v.e_we = e_we;
        v.e_dout = e_dout; v.e_rv = e_rv;   v.e_rd = e_rd;
        vq.push_back(v);
    endtask

    task automatic check_row(input int r, input vec_t v);
        string t;
        t = $sformatf("row%0d", r);
        chk({t, ".gnt"}, 32'(bus_a.gnt), 32'(v.e_gnt));
        chk({t, ".busy"}, 32'(bus_a.busy), 32'(v.e_gnt != 2'b00));
        if (v.e_gnt != 2'b00) chk({t, ".owner"}, 32'(bus_a.owner), v.e_gnt[1] ? 32'd1 : 32'd0);
        chk({t, ".we"}, 32'(bus_a.BRAM_we), 32'(v.e_we));
        if (v.e_chk) chk({t, ".addr"}, 32'(bus_a.BRAM_addr), 32'(v.e_addr));
        if (v.e_we) chk({t, ".dout"}, bus_a.BRAM_dout, v.e_dout);
        chk({t, ".rv"}, 32'(bus_a.rd_valid), 32'(v.e_rv));
        if (v.e_rv != 2'b00) chk({t, ".rdata"}, bus_a.rd_data, v.e_rd);
    endtask

    // Hold-timeout sequence on the 2-client instance (client 0 alone first, then contention).
    localparam logic [1:0] H_REQ [17] = '{2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01,
                                          2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00};
    localparam logic [1:0] H_GNT [17] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10,
                                          2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00};
    localparam int RR_ORDER [5] = '{0, 1, 2, 3, 0};

    task automatic cyc_a(input logic [1:0] req, input logic [1:0] we, input logic [7:0] a0,
                         input logic [7:0] a1, input logic [31:0] d1);
        @(posedge clk);
        #1;
        bus_a.req = req;
        bus_a.cl_we = we;
        bus_a.cl_addr = {a1, a0};
        bus_a.cl_dout = {d1, 32'h0};
        @(negedge clk);
    endtask

    task automatic cyc_b(input logic [3:0] req, input logic [3:0] we, input logic [31:0] addr);
        @(posedge clk);
        #1;
        bus_b.req = req;
        bus_b.cl_we = we;
        bus_b.cl_addr = addr;
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] oh;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        bus_a.req = '0; bus_a.cl_we = '0; bus_a.cl_addr = '0; bus_a.cl_dout = '0;
        bus_b.req = '0; bus_b.cl_we = '0; bus_b.cl_addr = '0; bus_b.cl_dout = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a.gnt", 32'(bus_a.gnt), 0);
        chk("rst_a.busy", 32'(bus_a.busy), 0);
        chk("rst_a.owner", 32'(bus_a.owner), 0);
        chk("rst_a.rv", 32'(bus_a.rd_valid), 0);
        chk("rst_a.we", 32'(bus_a.BRAM_we), 0);
        chk("rst_a.addr", 32'(bus_a.BRAM_addr), 0);
        chk("rst_b.gnt", 32'(bus_b.gnt), 0);
        chk("rst_b.busy", 32'(bus_b.busy), 0);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;

        //   req    we     a0     a1     d1             gnt    chk addr   we    dout           rv     rdata
        add(2'b00, 2'b00, 8'd0,  8'd0,  32'h0,         2'b00, 1, 8'd0,  1'b0, 32'h0,         2'b00, 32'h0);
        add(2'b01, 2'b00, 8'd5,  8'd0,  32'h0,         2'b00, 1, 8'd0,  1'b0, 32'h0,         2'b00, 32'h0);
        add(2'b01, 2'b00, 8'd5,  8'd0,  32'h0,         2'b01, 1, 8'd5,  1'b0, 32'h0,         2'b00, 32'h0);
        add(2'b01, 2'b00, 8'd10, 8'd0,  32'h0,         2'b01, 1, 8'd10, 1'b0, 32'h0,         2'b00, 32'h0);
        add(2'b01, 2'b00, 8'd7,  8'd0,  32'h0,         2'b01, 1, 8'd7,  1'b0, 32'h0,         2'b01, iw(5));
        add(2'b00, 2'b00, 8'd7,  8'd0,  32'h0,         2'b01, 0, 8'd0,  1'b0, 32'h0,         2'b01, iw(10));
        add(2'b00, 2'b00, 8'd0,  8'd0,  32'h0,         2'b00, 1, 8'd0,  1'b0, 32'h0,         2'b01, iw(7));
        add(2'b11, 2'b00, 8'd1,  8'd2,  32'h0,         2'b00, 1, 8'd0,  1'b0, 32'h0,         2'b00, 32'h0);
        add(2'b11, 2'b00, 8'd1,  8'd2,  32'h0,         2'b01, 1, 8'd1,  1'b0, 32'h0,         2'b00, 32'h0);
        add(2'b10, 2'b01, 8'd1,  8'd2,  32'h0,         2'b01, 0, 8'd0,  1'b0, 32'h0,         2'b00, 32'h0);
        add(2'b10, 2'b00, 8'd1,  8'd2,  32'h0,         2'b10, 1, 8'd2,  1'b0, 32'h0,         2'b01, iw(1));
        add(2'b10, 2'b10, 8'd0,  8'd9,  32'hDEADBEEF,  2'b10, 1, 8'd9,  1'b1, 32'hDEADBEEF,  2'b00, 32'h0);
        add(2'b00, 2'b10, 8'd0,  8'd9,  32'hDEADBEEF,  2'b10, 0, 8'd0,  1'b0, 32'h0,         2'b10, iw(2));
        add(2'b00, 2'b00, 8'd0,  8'd0,  32'h0,         2'b00, 1, 8'd0,  1'b0, 32'h0,         2'b00, 32'h0);
        add(2'b10, 2'b00, 8'd0,  8'd9,  32'h0,         2'b00, 1, 8'd0,  1'b0, 32'h0,         2'b00, 32'h0);
        add(2'b10, 2'b00, 8'd0,  8'd9,  32'h0,         2'b10, 1, 8'd9,  1'b0, 32'h0,         2'b00, 32'h0);
        add(2'b00, 2'b00, 8'd0,  8'd9,  32'h0,         2'b10, 0, 8'd0,  1'b0, 32'h0,         2'b00, 32'h0);
        add(2'b00, 2'b00, 8'd0,  8'd0,  32'h0,         2'b00, 1, 8'd0,  1'b0, 32'h0,         2'b10, 32'hDEADBEEF);
        add(2'b01, 2'b00, 8'd3,  8'd0,  32'h0,         2'b00, 1, 8'd0,  1'b0, 32'h0,         2'b00, 32'h0);
        add(2'b01, 2'b00, 8'd3,  8'd0,  32'h0,         2'b01, 1, 8'd3,  1'b0, 32'h0,         2'b00, 32'h0);
        add(2'b10, 2'b00, 8'd3,  8'd4,  32'h0,         2'b01, 0, 8'd0,  1'b0, 32'h0,         2'b00, 32'h0);
        add(2'b10, 2'b10, 8'd3,  8'd4,  32'hCAFEF00D,  2'b10, 1, 8'd4,  1'b1, 32'hCAFEF00D,  2'b01, iw(3));
        add(2'b00, 2'b10, 8'd0,  8'd4,  32'hCAFEF00D,  2'b10, 0, 8'd0,  1'b0, 32'h0,         2'b00, 32'h0);
        add(2'b00, 2'b00, 8'd0,  8'd0,  32'h0,         2'b00, 1, 8'd0,  1'b0, 32'h0,         2'b00, 32'h0);

        foreach (vq[r]) begin
            cyc_a(vq[r].req, vq[r].we, vq[r].a0, vq[r].a1, vq[r].d1);
            check_row(r, vq[r]);
        end

        for (int s = 0; s < 17; s++) begin
            cyc_a(H_REQ[s], 2'b00, 8'd0, 8'd0, 32'h0);
            chk($sformatf("hold%0d.gnt", s), 32'(bus_a.gnt), 32'(H_GNT[s]));
        end

        // Round-robin: every client requests, each owner holds 3 cycles then drops for one.
        cyc_b(4'b1111, 4'b1111, 32'h23222120);
        chk("rr.start.gnt", 32'(bus_b.gnt), 0);
        for (int k = 0; k < 5; k++) begin
            oh = 4'(1) << RR_ORDER[k];
            for (int j = 0; j < 4; j++) begin
                cyc_b((j < 3) ? 4'b1111 : (4'b1111 & ~oh), 4'b1111, 32'h23222120);
                chk($sformatf("rr%0d.%0d.gnt", k, j), 32'(bus_b.gnt), 32'(oh));
                chk($sformatf("rr%0d.%0d.we", k, j), 32'(bus_b.BRAM_we), (j < 3) ? 32'd1 : 32'd0);
                if (j == 0) chk($sformatf("rr%0d.addr", k), 32'(bus_b.BRAM_addr), 32'h20 + 32'(RR_ORDER[k]));
            end
        end
        cyc_b(4'b0000, 4'b0000, 32'h0);
        chk("rr.tail.gnt", 32'(bus_b.gnt), 32'h2);
        cyc_b(4'b0000, 4'b0000, 32'h0);
        chk("rr.idle.gnt", 32'(bus_b.gnt), 0);

        // Reset mid-burst with two reads in flight on the latency-3 instance.
        bus_b.cl_dout = {32'h0, 32'hABCD0002, 64'h0};
        cyc_b(4'b0100, 4'b0000, 32'h00010000);
        chk("rb.u0.gnt", 32'(bus_b.gnt), 0);
        cyc_b(4'b0100, 4'b0000, 32'h00010000);
        chk("rb.u1.addr", 32'(bus_b.BRAM_addr), 32'd1);
        cyc_b(4'b0100, 4'b0000, 32'h00020000);
        chk("rb.u2.owner", 32'(bus_b.owner), 32'd2);
        @(posedge clk);
        #2;
        chk("rb.pre.dout", bus_b.BRAM_dout, 32'hABCD0002);
        rst_n_b = 1'b0;
        #1;
        chk("rb.gnt", 32'(bus_b.gnt), 0);
        chk("rb.busy", 32'(bus_b.busy), 0);
        chk("rb.owner", 32'(bus_b.owner), 0);
        chk("rb.rv", 32'(bus_b.rd_valid), 0);
        chk("rb.we", 32'(bus_b.BRAM_we), 0);
        chk("rb.addr", 32'(bus_b.BRAM_addr), 0);
        chk("rb.dout", bus_b.BRAM_dout, 0);
        bus_b.req = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        rst_n_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc_b(4'b0000, 4'b0000, 32'h0);
            chk($sformatf("rb.post%0d.rv", i), 32'(bus_b.rd_valid), 0);
        end
        cyc_b(4'b1010, 4'b0000, 32'h00000600);
        chk("rb.v0.gnt", 32'(bus_b.gnt), 0);
        cyc_b(4'b1010, 4'b0000, 32'h00000600);
        chk("rb.v1.gnt", 32'(bus_b.gnt), 32'h2);
        chk("rb.v1.addr", 32'(bus_b.BRAM_addr), 32'd6);
        cyc_b(4'b0000, 4'b0000, 32'h0);
        chk("rb.v2.rv", 32'(bus_b.rd_valid), 0);
        cyc_b(4'b0000, 4'b0000, 32'h0);
        chk("rb.v3.rv", 32'(bus_b.rd_valid), 0);
        chk("rb.v3.gnt", 32'(bus_b.gnt), 0);
        cyc_b(4'b0000, 4'b0000, 32'h0);
        chk("rb.v4.rv", 32'(bus_b.rd_valid), 32'h2);
        chk("rb.v4.rdata", bus_b.rd_data, iw(6));
        cyc_b(4'b0000, 4'b0000, 32'h0);
        chk("rb.v5.rv", 32'(bus_b.rd_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
